// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory controller.
package lsu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RMW_READ,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Illegal size is always an error; misalignment only when checking is enabled.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo,
                                      input logic check);
    access_err = (size == 2'b11) ||
                 (check && (((size == SZ_HALF) && lo[0]) ||
                            ((size == SZ_WORD) && (lo != 2'b00))));
  endfunction

  function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_HALF: force_align = {lo[1], 1'b0};
      SZ_WORD: force_align = 2'b00;
      default: force_align = lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extract/extend a load lane, or merge store data into an old word.
// Purely combinational; little-endian lanes selected by the low address bits.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] rd_word,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rd_word[{offset, 3'b000} +: 8];
    half_lane = rd_word[{offset[1], 4'b0000} +: 16];
    load_data = rd_word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
        merged    = rd_word;
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{is_signed & half_lane[15]}}, half_lane};
        merged    = rd_word;
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Core-side load/store initiator for a word-only data memory; sub-word stores use read-modify-write.
// Latency (MEM_LAT=1): load/word store 2, sub-word store 3, error 1; req_ready low until back in IDLE.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_LAT     = 1,
  parameter bit CHECK_ALIGN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [WORD_W-1:0] memAddress,
  output logic [WORD_W-1:0] memWriteData,
  output logic              memRead,
  output logic              memWrite,
  input  logic [WORD_W-1:0] memReadData
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  state_t            state;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic              signed_q;
  logic [CW-1:0]     cnt_q;
  logic [WORD_W-1:0] load_data;
  logic [WORD_W-1:0] merged;

  assign req_ready = (state == IDLE);

  lsu_lane_align u_align (
    .rd_word  (memReadData),
    .offset   (addr_q[1:0]),
    .size     (size_q),
    .is_signed(signed_q),
    .wdata    (wdata_q),
    .load_data(load_data),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      cnt_q        <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      memAddress   <= '0;
      memWriteData <= '0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= {req_addr[WORD_W-1:2],
                           CHECK_ALIGN ? req_addr[1:0] : force_align(req_size, req_addr[1:0])};
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            write_q    <= req_write;
            signed_q   <= req_signed;
            cnt_q      <= '0;
            memAddress <= {req_addr[WORD_W-1:2], 2'b00};
            if (access_err(req_size, req_addr[1:0], CHECK_ALIGN)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_write) begin
              state   <= READ;
              memRead <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state        <= WRITE;
              memWrite     <= 1'b1;
              memWriteData <= req_wdata;
            end else begin
              state   <= RMW_READ;
              memRead <= 1'b1;
            end
          end
        end
        READ, RMW_READ: begin
          // memReadData is consumed on the edge that ends the last wait cycle.
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            memRead <= 1'b0;
            if (write_q) begin
              state        <= WRITE;
              memWrite     <= 1'b1;
              memWriteData <= merged;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WRITE: begin
          memWrite   <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          state        <= IDLE;
          memAddress   <= '0;
          memWriteData <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: MEM_LAT=1 and MEM_LAT=3 instances, each with a negedge-sampling memory model.
module tb_lsu_mem_ctrl;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_write    [2];
  logic [1:0]  req_size     [2];
  logic        req_signed   [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        resp_valid   [2];
  logic [31:0] resp_rdata   [2];
  logic        resp_err     [2];
  logic [31:0] memAddress   [2];
  logic [31:0] memWriteData [2];
  logic        memRead      [2];
  logic        memWrite     [2];
  logic [31:0] mrd          [2];
  logic [31:0] mem          [2][16];
  logic        preload;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];

  lsu_mem_ctrl #(.MEM_LAT(1), .CHECK_ALIGN(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .memAddress(memAddress[0]), .memWriteData(memWriteData[0]),
    .memRead(memRead[0]), .memWrite(memWrite[0]), .memReadData(mrd[0])
  );

  lsu_mem_ctrl #(.MEM_LAT(3), .CHECK_ALIGN(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .memAddress(memAddress[1]), .memWriteData(memWriteData[1]),
    .memRead(memRead[1]), .memWrite(memWrite[1]), .memReadData(mrd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (preload) begin
        for (int j = 0; j < 16; j++) mem[k][j] <= (j == 4) ? 32'h8899AABB : 32'h0;
        mrd[k] <= 32'h0;
      end else begin
        if (memRead[k]) mrd[k] <= mem[k][memAddress[k][5:2]];
        if (memWrite[k]) mem[k][memAddress[k][5:2]] <= memWriteData[k];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Response scoreboard: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic have;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mem_excl%0d", k), {31'b0, memRead[k] & memWrite[k]}, 32'h0);
      if (resp_valid[k] === 1'b1) begin
        have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
        checks++;
        assert (have) else begin
          errors++;
          $error("FAIL unexpected_resp%0d: observed resp_valid=1 expected no response", k);
        end
        if (have) begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("resp_cycle%0d", k), cyc, e.cyc);
          chk($sformatf("resp_rdata%0d", k), resp_rdata[k], e.rdata);
          chk($sformatf("resp_err%0d", k), {31'b0, resp_err[k]}, {31'b0, e.err});
        end
      end else if (rst_n) begin
        chk($sformatf("idle_resp%0d", k), {resp_rdata[k][30:0], resp_err[k]}, 32'h0);
      end
    end
  end

  // Starts just after a posedge with the DUT idle; returns just after the posedge
  // of the first IDLE cycle following the response, so calls chain back-to-back.
  task automatic run(input int k, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int lat,
                     input logic [7:0] rdm, input logic [7:0] wrm, input logic [31:0] exp_wd);
    exp_t e;
    req_valid[k]  = 1'b1;
    req_write[k]  = wr;
    req_size[k]   = sz;
    req_signed[k] = sg;
    req_addr[k]   = addr;
    req_wdata[k]  = wd;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.cyc   = cyc + lat;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      chk($sformatf("memRead%0d_c%0d", k, c), {31'b0, memRead[k]}, {31'b0, rdm[c]});
      chk($sformatf("memWrite%0d_c%0d", k, c), {31'b0, memWrite[k]}, {31'b0, wrm[c]});
      chk($sformatf("req_ready%0d_c%0d", k, c), {31'b0, req_ready[k]}, (c == 0) ? 32'h1 : 32'h0);
      if (c == 0) chk($sformatf("idle_addr%0d", k), memAddress[k], 32'h0);
      if (rdm[c] || wrm[c])
        chk($sformatf("memAddress%0d_c%0d", k, c), memAddress[k], {addr[31:2], 2'b00});
      if (wrm[c]) chk($sformatf("memWriteData%0d", k), memWriteData[k], exp_wd);
      @(posedge clk);
      #1;
      if (c == 0) req_valid[k] = 1'b0;
    end
    chk($sformatf("ready_after%0d", k), {31'b0, req_ready[k]}, 32'h1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_size[k] = 2'b00;
      req_signed[k] = 1'b0; req_addr[k] = 32'h0; req_wdata[k] = 32'h0;
    end
    rst_n   = 1'b0;
    preload = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_resp_valid", {31'b0, resp_valid[k]}, 32'h0);
      chk("rst_mem_en", {30'b0, memRead[k], memWrite[k]}, 32'h0);
      chk("rst_memAddress", memAddress[k], 32'h0);
      chk("rst_memWriteData", memWriteData[k], 32'h0);
      chk("rst_resp_rdata", resp_rdata[k], 32'h0);
    end
    @(negedge clk);
    preload = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready0", {31'b0, req_ready[0]}, 32'h1);
    chk("rst_ready1", {31'b0, req_ready[1]}, 32'h1);

    // MEM_LAT=1 instance
    run(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFF88, 0, 2, 8'b010, 8'b000, 32'h0);
    run(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'h00000088, 0, 2, 8'b010, 8'b000, 32'h0);
    run(0, 1, 2'b01, 0, 32'h12, 32'hFFFF1234, 32'h0, 0, 3, 8'b0010, 8'b0100, 32'h1234AABB);
    chk("mem_after_half", mem[0][4], 32'h1234AABB);
    run(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h1234AABB, 0, 2, 8'b010, 8'b000, 32'h0);
    run(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 8'b000, 8'b010, 32'hDEADBEEF);
    chk("mem_after_word", mem[0][4], 32'hDEADBEEF);
    run(0, 0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1, 1, 8'b00, 8'b00, 32'h0);
    run(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1, 8'b00, 8'b00, 32'h0);
    run(0, 1, 2'b01, 0, 32'h13, 32'h1, 32'h0, 1, 1, 8'b00, 8'b00, 32'h0);
    run(0, 0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 2, 8'b010, 8'b000, 32'h0);

    // Reset in the middle of a byte read-modify-write
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'b00;
    req_signed[0] = 1'b0; req_addr[0] = 32'h10; req_wdata[0] = 32'h55;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    chk("abort_memRead_pre", {31'b0, memRead[0]}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_memRead", {31'b0, memRead[0]}, 32'h0);
    chk("abort_memWrite", {31'b0, memWrite[0]}, 32'h0);
    chk("abort_memAddress", memAddress[0], 32'h0);
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_write", {31'b0, memWrite[0]}, 32'h0);
    end
    chk("abort_mem_word", mem[0][4], 32'hDEADBEEF);
    chk("abort_ready", {31'b0, req_ready[0]}, 32'h1);
    @(posedge clk);
    #1;

    // MEM_LAT=3 instance, back-to-back requests
    run(1, 0, 2'b01, 0, 32'h10, 32'h0, 32'h0000AABB, 0, 4, 8'b01110, 8'b00000, 32'h0);
    run(1, 0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFF8899, 0, 4, 8'b01110, 8'b00000, 32'h0);
    run(1, 1, 2'b00, 0, 32'h11, 32'h55, 32'h0, 0, 5, 8'b001110, 8'b010000, 32'h889955BB);
    run(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h889955BB, 0, 4, 8'b01110, 8'b00000, 32'h0);
    run(1, 0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1, 1, 8'b00, 8'b00, 32'h0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", q0.size() + q1.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Processor-side initiator for the word-addressed data memory.
- Accepts byte, halfword and word load/store requests from the core over a valid/ready handshake.
- Drives the memory's memRead/memWrite/address/writeData interface and returns aligned, extended load data.
- Sub-word stores are done as a read-modify-write, because the memory only writes whole 32-bit words.

Parameters:
- MEM_LAT, 1: cycles memRead is held before memReadData is sampled. Must be ≥1. 1 matches the negedge-sampling memory.
- CHECK_ALIGN, 1: 1 flags misaligned accesses as errors. 0 forces addr low bits to 0 for the access width.

Ports:
- clk  in  1  clock, all flops on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_err  out  1  misaligned or illegal size, valid with resp_valid
- memAddress  out  32  byte address to memory, always {addr[31:2],2'b00}
- memWriteData  out  32  full word to memory
- memRead  out  1  memory read enable
- memWrite  out  1  memory write enable
- memReadData  in  32  memory read data

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - resp_valid, resp_err, memRead and memWrite are 0. resp_rdata, memAddress and memWriteData are 0.
  - Latched request registers are 0. Wait counter is 0.
  - req_ready = (state==IDLE), so it reads 1 once reset is released.
- FSM states: IDLE, READ, RMW_READ, WRITE, RESP.
- IDLE:
  - A request is accepted when req_valid & req_ready at a posedge. Accept latches addr, size, write, signed and wdata.
  - Error = illegal size, or (CHECK_ALIGN and (half & addr[0], or word & addr[1:0]≠0)).
  - Transitions: error → RESP with err=1. Load → READ. Word store → WRITE. Byte/half store → RMW_READ.
- READ / RMW_READ:
  - memRead=1 for MEM_LAT cycles, counted by the wait counter.
  - At the posedge ending the last cycle, memReadData is captured.
  - READ: extract lane addr[1:0] (little-endian), zero- or sign-extend, → RESP.
  - RMW_READ: merge req_wdata into the selected byte/half lane of the captured word, → WRITE.
- WRITE: memWrite=1 for exactly one cycle. memWriteData = merged word (sub-word) or req_wdata (word). → RESP.
- RESP: resp_valid=1 for exactly one cycle. resp_rdata and resp_err held that cycle, 0 otherwise. → IDLE. No backpressure on the response.
- Latency, counting the accept cycle as cycle 0, for MEM_LAT=1:
  - Load: resp_valid in cycle 2.
  - Word store: resp_valid in cycle 2.
  - Sub-word store: resp_valid in cycle 3.
  - Error: resp_valid in cycle 1.
  - Each extra MEM_LAT cycle adds 1 to READ/RMW_READ paths.
- Memory-interface rules:
  - memRead and memWrite are never both 1.
  - All memory outputs are decoded from registered state only, so they are stable before the negedge the memory samples on.
  - memAddress holds the latched aligned address throughout the transaction, and 0 in IDLE.
  - Error requests never assert memRead or memWrite.
- Back-to-back: req_ready=0 from the accept edge until the cycle after RESP. The next accept is possible in the first IDLE cycle.
- Reset mid-operation: all memory enables drop immediately (async). A sub-word store interrupted before WRITE leaves memory unchanged. No resp_valid is produced for the aborted request.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package lsu_pkg holds:
  - state enum (IDLE, READ, RMW_READ, WRITE, RESP)
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - word width constant 32
- One combinational sub-module, lsu_lane_align:
  - load side: extract + extend given word, addr[1:0], size, signed
  - store side: merge given old word, wdata, addr[1:0], size
- FSM and wait counter stay in lsu_mem_ctrl.

Test Plan (preload mem word @0x10 = 0x8899AABB):
- Word store addr 0x10, wdata 0xDEADBEEF → memWrite=1 only in cycle 1, memAddress=0x10, memWriteData=0xDEADBEEF; resp_valid cycle 2, resp_err=0; word now 0xDEADBEEF.
- Byte load addr 0x13: signed → resp_rdata=0xFFFFFF88; unsigned → 0x00000088; memRead=1 cycle 1 only, resp_valid cycle 2.
- Half store 0x1234 @0x12 → memRead cycle 1, memWrite cycle 2 with memWriteData=0x1234AABB, resp_valid cycle 3; subsequent word load returns 0x1234AABB.
- Word load @0x11 (CHECK_ALIGN=1) → resp_valid cycle 1, resp_err=1, resp_rdata=0, memRead/memWrite never 1. Same response for req_size=11.
- Byte store 0x55 @0x10, rst_n pulsed low during RMW_READ → memRead drops asynchronously, no memWrite, no resp_valid, word unchanged; req_ready=1 after release.
- MEM_LAT=3, half load @0x10 unsigned → memRead high cycles 1-3, resp_valid cycle 4, resp_rdata=0x0000AABB. Two back-to-back requests: second accepted the first IDLE cycle after the RESP cycle.
